// File: rtl/vector_lsu_pkg.sv
// Shared definitions for the vector load/store unit and its neighbours
// (memory and register-file blocks reuse the width defaults).
package vector_lsu_pkg;

  localparam int unsigned AddrWDef = 9;
  localparam int unsigned DataWDef = 512;
  localparam int unsigned RegWDef  = 3;
  // Burst length field carries beats minus one, so 2 bits covers 1..4 beats.
  localparam int unsigned LenW     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLdIssue,
    StLdCapture,
    StStIssue
  } lsu_state_e;

endpackage

// File: rtl/vector_lsu_if.sv
// Command, register-file and memory signals of the vector LSU.
// slave: the LSU's view; master: the environment driving commands and
// providing register-file/memory responses.
interface vector_lsu_if
  import vector_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_W  = RegWDef
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_store;
  logic [ADDR_W-1:0] cmd_addr;
  logic [REG_W-1:0]  cmd_reg;
  logic [LenW-1:0]   cmd_len;

  logic [REG_W-1:0]  rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              rf_write_enable;
  logic [REG_W-1:0]  rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_read_address;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_out;

  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_store, cmd_addr, cmd_reg, cmd_len, rf_read_data, mem_out,
    output cmd_ready, rf_read_addr, rf_write_enable, rf_write_addr, rf_write_data,
    output mem_read_enable, mem_read_address, mem_write_enable, mem_write_address,
    output mem_data, busy, done
  );

  modport master (
    output cmd_valid, cmd_store, cmd_addr, cmd_reg, cmd_len, rf_read_data, mem_out,
    input  cmd_ready, rf_read_addr, rf_write_enable, rf_write_addr, rf_write_data,
    input  mem_read_enable, mem_read_address, mem_write_enable, mem_write_address,
    input  mem_data, busy, done
  );

endinterface

// File: rtl/lsu_beat_counter.sv
// Beat index for a burst plus the per-beat memory address and register index,
// both wrapping naturally at their field widths.
module lsu_beat_counter
  import vector_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned REG_W  = RegWDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [REG_W-1:0]  base_reg_i,
  output logic [LenW-1:0]   beat_o,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic [REG_W-1:0]  beat_reg_o
);

  logic [LenW-1:0] beat_q, beat_d;

  // Next beat: clear on command accept, step after each completed beat.
  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (advance_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // Beat register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  // Truncating adds give the modulo wrap (511 -> 0, register 7 -> 0).
  always_comb begin
    beat_o      = beat_q;
    beat_addr_o = base_addr_i + ADDR_W'(beat_q);
    beat_reg_o  = base_reg_i + REG_W'(beat_q);
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves 1..4 consecutive vector words between memory
// and the vector register file. Loads take two cycles per beat (issue, then
// capture the registered memory data); stores take one cycle per beat.
module vector_lsu
  import vector_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_W  = RegWDef
) (
  input logic         clk,
  input logic         reset,
  vector_lsu_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [LenW-1:0]   len_q, len_d;
  logic              store_q, store_d;
  logic              done_q, done_d;

  logic              cnt_clear;
  logic              cnt_advance;
  logic [LenW-1:0]   beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [REG_W-1:0]  beat_reg;
  logic              accept;
  logic              last_beat;

  lsu_beat_counter #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_beat_counter (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .advance_i   (cnt_advance),
    .base_addr_i (addr_q),
    .base_reg_i  (reg_q),
    .beat_o      (beat),
    .beat_addr_o (beat_addr),
    .beat_reg_o  (beat_reg)
  );

  // Next-state and all datapath outputs; anything not driven by the current
  // state stays 0. Enables are also held low while reset is high so an abort
  // cannot land one last write on the reset edge.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    reg_d       = reg_q;
    len_d       = len_q;
    store_d     = store_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    bus.cmd_ready         = (state_q == StIdle) && !reset;
    bus.rf_read_addr      = '0;
    bus.rf_write_enable   = 1'b0;
    bus.rf_write_addr     = '0;
    bus.rf_write_data     = '0;
    bus.mem_read_enable   = 1'b0;
    bus.mem_read_address  = '0;
    bus.mem_write_enable  = 1'b0;
    bus.mem_write_address = '0;
    bus.mem_data          = '0;

    accept    = bus.cmd_valid && (state_q == StIdle) && !reset;
    last_beat = (beat == len_q);

    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_d    = bus.cmd_addr;
            reg_d     = bus.cmd_reg;
            len_d     = bus.cmd_len;
            store_d   = bus.cmd_store;
            cnt_clear = 1'b1;
            state_d   = bus.cmd_store ? StStIssue : StLdIssue;
          end
        end
        StLdIssue: begin
          bus.mem_read_enable  = 1'b1;
          bus.mem_read_address = beat_addr;
          state_d              = StLdCapture;
        end
        StLdCapture: begin
          bus.rf_write_enable = 1'b1;
          bus.rf_write_addr   = beat_reg;
          bus.rf_write_data   = bus.mem_out;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_advance = 1'b1;
            state_d     = StLdIssue;
          end
        end
        StStIssue: begin
          bus.rf_read_addr      = beat_reg;
          bus.mem_write_enable  = 1'b1;
          bus.mem_write_address = beat_addr;
          bus.mem_data          = bus.rf_read_data;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_advance = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and latched command fields, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
      store_q <= store_d;
      done_q  <= done_d;
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = done_q;
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: behavioural memory and register file,
// expected transfers queued per command and compared against observed ones.
module tb_vector_lsu;
  import vector_lsu_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 512;
  localparam int unsigned RW = 3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [RW-1:0] rg;
    logic [DW-1:0] data;
  } ev_t;

  localparam logic [1:0] EvRead  = 2'd1;
  localparam logic [1:0] EvWrite = 2'd2;
  localparam logic [1:0] EvRf    = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vector_lsu_if bus ();

  vector_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment models.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rf  [2**RW];
  logic [DW-1:0] mem_out_r;
  logic          pre_mem_we, pre_rf_we;
  logic [AW-1:0] pre_mem_a;
  logic [RW-1:0] pre_rf_a;
  logic [DW-1:0] pre_mem_d, pre_rf_d;

  assign bus.mem_out      = mem_out_r;
  assign bus.rf_read_data = rf[bus.rf_read_addr];

  always @(posedge clk) begin
    if (pre_mem_we) mem[pre_mem_a] <= pre_mem_d;
    if (pre_rf_we) rf[pre_rf_a] <= pre_rf_d;
    if (bus.mem_write_enable) mem[bus.mem_write_address] <= bus.mem_data;
    if (bus.mem_read_enable) mem_out_r <= mem[bus.mem_read_address];
    if (bus.rf_write_enable) rf[bus.rf_write_addr] <= bus.rf_write_data;
  end

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  function automatic logic [DW-1:0] pat(input int unsigned a);
    pat = {16{32'hC0DE0000 + a}};
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input int unsigned a, input int unsigned r,
                             input logic [DW-1:0] d);
    mk.kind = k;
    mk.addr = AW'(a);
    mk.rg   = RW'(r);
    mk.data = d;
  endfunction

  // Record any transfer the DUT is making this cycle.
  task automatic snoop(output int ovl);
    ovl = (bus.mem_read_enable && bus.mem_write_enable) ? 1 : 0;
    if (bus.mem_read_enable) obs_q.push_back(mk(EvRead, bus.mem_read_address, 0, '0));
    if (bus.mem_write_enable)
      obs_q.push_back(mk(EvWrite, bus.mem_write_address, 0, bus.mem_data));
    if (bus.rf_write_enable) obs_q.push_back(mk(EvRf, 0, bus.rf_write_addr, bus.rf_write_data));
  endtask

  // Watch n cycles starting at the current negedge; ends on a negedge.
  task automatic collect(input int n, output int busy_cnt, output int done_idx,
                         output int n_done, output int overlap);
    int ovl;
    busy_cnt = 0; done_idx = -1; n_done = 0; overlap = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      snoop(ovl);
      overlap += ovl;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic st, input int unsigned a, input int unsigned r,
                      input int unsigned l);
    bus.cmd_valid = 1'b1;
    bus.cmd_store = st;
    bus.cmd_addr  = AW'(a);
    bus.cmd_reg   = RW'(r);
    bus.cmd_len   = LenW'(l);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned ma [7] = '{510, 511, 0, 1, 100, 101, 102};
    int unsigned ra [3] = '{2, 3, 4};
    logic [DW-1:0] rd [3];
    rd[0] = DW'(120); rd[1] = pat(903); rd[2] = pat(904);
    // Command held valid throughout reset must not be taken.
    bus.cmd_valid = 1'b1; bus.cmd_store = 1'b1; bus.cmd_addr = AW'(50);
    bus.cmd_reg = 3'd2; bus.cmd_len = 2'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pre_mem_we = 1'b1; pre_mem_a = AW'(ma[i]); pre_mem_d = pat(ma[i]);
      pre_rf_we = (i < 3); pre_rf_a = RW'(ra[i % 3]); pre_rf_d = rd[i % 3];
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b0 || bus.mem_write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: ready=%b mem_we=%b want 0/0", bus.cmd_ready,
                 bus.mem_write_enable);
      end
    end
    @(negedge clk);
    pre_mem_we = 1'b0; pre_rf_we = 1'b0;
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: ready=%b busy=%b done=%b want 1/0/0", bus.cmd_ready,
               bus.busy, bus.done);
    end
    n_checks++;
    if ({bus.mem_read_enable, bus.mem_write_enable, bus.rf_write_enable} !== 3'b000 ||
        bus.mem_read_address !== '0 || bus.mem_write_address !== '0 ||
        bus.rf_write_addr !== '0 || bus.rf_read_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%b ra=%0d wa=%0d rfw=%0d rfr=%0d want all 0",
               {bus.mem_read_enable, bus.mem_write_enable, bus.rf_write_enable},
               bus.mem_read_address, bus.mem_write_address, bus.rf_write_addr,
               bus.rf_read_addr);
    end
    n_checks++;
    if (bus.mem_data !== '0 || bus.rf_write_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: mem_data/rf_data nonzero, want 0");
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int b, d, nd, ov;
    ev_t e, o;
    send(1'b1, 10, 2, 0);
    exp_q.push_back(mk(EvWrite, 10, 0, DW'(120)));
    collect(3, b, d, nd, ov);
    n_checks++;
    if (b != 1 || d != 1 || nd != 1) begin
      n_fail++;
      $display("FAIL store1_timing: busy=%0d done_at=%0d ndone=%0d want 1/1/1", b, d, nd);
    end
    send(1'b0, 10, 5, 0);
    exp_q.push_back(mk(EvRead, 10, 0, '0));
    exp_q.push_back(mk(EvRf, 0, 5, DW'(120)));
    collect(4, b, d, nd, ov);
    n_checks++;
    if (b != 2 || d != 2 || nd != 1) begin
      n_fail++;
      $display("FAIL load1_timing: busy=%0d done_at=%0d ndone=%0d want 2/2/1", b, d, nd);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL store_load_ev: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL store_load_ev: got %h want %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL store_load_extra: got %0d extra transfers want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_load_wrap();
    int b, d, nd, ov;
    ev_t e, o;
    int unsigned aa [4] = '{510, 511, 0, 1};
    send(1'b0, 510, 6, 3);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(EvRead, aa[i], 0, '0));
      exp_q.push_back(mk(EvRf, 0, (6 + i) % 8, pat(aa[i])));
    end
    collect(12, b, d, nd, ov);
    n_checks++;
    if (b != 8 || d != 8 || nd != 1) begin
      n_fail++;
      $display("FAIL load4_timing: busy=%0d done_at=%0d ndone=%0d want 8/8/1", b, d, nd);
    end
    n_checks++;
    if (ov != 0) begin
      n_fail++;
      $display("FAIL load4_overlap: got %0d cycles with both enables want 0", ov);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL load4_ev: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL load4_ev: got %h want %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL load4_extra: got %0d extra transfers want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int b, d, nd, ov;
    ev_t e, o;
    send(1'b1, 20, 3, 1);
    exp_q.push_back(mk(EvWrite, 20, 0, pat(903)));
    exp_q.push_back(mk(EvWrite, 21, 0, pat(904)));
    collect(2, b, d, nd, ov);
    #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 || b != 2) begin
      n_fail++;
      $display("FAIL store2_done: done=%b ready=%b busy=%0d want 1/1/2", bus.done,
               bus.cmd_ready, b);
    end
    // Next command issued in the done cycle.
    send(1'b0, 20, 0, 0);
    exp_q.push_back(mk(EvRead, 20, 0, '0));
    exp_q.push_back(mk(EvRf, 0, 0, pat(903)));
    collect(4, b, d, nd, ov);
    n_checks++;
    if (b != 2 || d != 2) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%0d done_at=%0d want 2/2", b, d);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_ev: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b_ev: got %h want %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_extra: got %0d extra transfers want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    int b, d, nd, ov;
    ev_t e, o;
    send(1'b0, 100, 1, 2);
    exp_q.push_back(mk(EvRead, 100, 0, '0));
    exp_q.push_back(mk(EvRf, 0, 1, pat(100)));
    exp_q.push_back(mk(EvRead, 101, 0, '0));
    collect(3, b, d, nd, ov);
    // Now in the capture cycle of beat 2.
    reset = 1'b1;
    #1;
    snoop(ov);
    n_checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.mem_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_write: rf_we=%b mem_re=%b want 0/0", bus.rf_write_enable,
               bus.mem_read_enable);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0 ||
        bus.rf_write_data !== '0 || bus.rf_write_addr !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b ready=%b want 0/0/0 and zero data",
               bus.busy, bus.done, bus.cmd_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: ready=%b want 1", bus.cmd_ready);
    end
    @(negedge clk);
    collect(6, b, d, nd, ov);
    n_checks++;
    if (b != 0 || nd != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: busy=%0d ndone=%0d want 0/0", b, nd);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL abort_ev: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL abort_ev: got %h want %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_extra: got %0d extra transfers want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_hold_valid();
    int ov, nd;
    ev_t e, o;
    logic exp_ready [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    nd = 0;
    bus.cmd_valid = 1'b1; bus.cmd_store = 1'b1; bus.cmd_addr = AW'(30);
    bus.cmd_reg = 3'd2; bus.cmd_len = 2'd1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(EvWrite, 30, 0, DW'(120)));
      exp_q.push_back(mk(EvWrite, 31, 0, pat(903)));
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      snoop(ov);
      if (bus.done) nd++;
      n_checks++;
      if (bus.cmd_ready !== exp_ready[i]) begin
        n_fail++;
        $display("FAIL hold_ready[%0d]: ready=%b want %b", i, bus.cmd_ready, exp_ready[i]);
      end
      if (i == 3) bus.cmd_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (nd != 2) begin
      n_fail++;
      $display("FAIL hold_done: got %0d done pulses want 2", nd);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL hold_ev: got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL hold_ev: got %h want %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_extra: got %0d extra transfers want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_store = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_reg   = '0;
    bus.cmd_len   = '0;
    pre_mem_we = 1'b0; pre_rf_we = 1'b0;
    pre_mem_a = '0; pre_rf_a = '0; pre_mem_d = '0; pre_rf_d = '0;
    test_reset();
    test_store_load();
    test_load_wrap();
    test_back_to_back();
    test_reset_abort();
    test_hold_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
